// File: rtl/bus_xfer_if.sv
// Command and bus-control signals between the command master and bus_xfer_ctrl.
interface bus_xfer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_src;
    logic [2:0] cmd_dst;
    logic [7:0] cmd_data;
    logic [7:0] bus_data;
    logic       eni, ena, enb, enc;
    logic       lda, ldb, ldc;
    logic       done;
    logic       err;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data,
        input  cmd_ready, bus_data, eni, ena, enb, enc, lda, ldb, ldc, done, err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data,
        output cmd_ready, bus_data, eni, ena, enb, enc, lda, ldb, ldc, done, err, busy
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer sequencer: command FIFO plus an FSM that drives one bus driver per cycle.
// Optional macro SWAP_EN adds the 3-cycle A<->B swap (SW1..SW3); without it op 1 is illegal.
module bus_xfer_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic       clk,
    input logic       rst_n,
    bus_xfer_if.slave bus
);

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] src;
        logic [2:0] dst;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        XFER = 3'd1
`ifdef SWAP_EN
        ,
        SW1  = 3'd2,
        SW2  = 3'd3,
        SW3  = 3'd4
`endif
    } state_t;

`ifdef SWAP_EN
    localparam logic SWAP_OK = 1'b1;
`else
    localparam logic SWAP_OK = 1'b0;
`endif
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [7:0]    bus_data_q, bus_data_d;
    logic [3:0]    en_q, en_d;   // [0]=in [1]=A [2]=B [3]=C
    logic [2:0]    ld_q, ld_d;   // [0]=A [1]=B [2]=C
    logic          done_q, done_d, err_q, err_d;

    logic full, empty, push, pop, take, illegal;
    cmd_t cmd_in, head;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign push    = bus.cmd_valid && !full;
    assign cmd_in  = '{op: bus.cmd_op, src: bus.cmd_src, dst: bus.cmd_dst, data: bus.cmd_data};
    assign head    = mem_q[rd_ptr_q];
    assign illegal = (head.dst == 3'b000) || head.op[1] || ((head.op == 2'd1) && !SWAP_OK);

    // A new command may start from IDLE or right after the final step of the previous one.
`ifdef SWAP_EN
    assign take = !empty && (state_q == IDLE || state_q == XFER || state_q == SW3);
`else
    assign take = !empty && (state_q == IDLE || state_q == XFER);
`endif

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        en_d       = '0;
        ld_d       = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        bus_data_d = bus_data_q;
        if (take) begin
            pop = 1'b1;
            if (illegal) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else if (head.op == 2'd0) begin
                state_d           = XFER;
                en_d[head.src]    = 1'b1;
                ld_d              = head.dst;
                done_d            = 1'b1;
                if (head.src == 2'd0) bus_data_d = head.data;
            end
`ifdef SWAP_EN
            else begin
                state_d = SW1;
                en_d[1] = 1'b1;
                ld_d[2] = 1'b1;
            end
`endif
        end else begin
            state_d = IDLE;
`ifdef SWAP_EN
            if (state_q == SW1) begin
                state_d = SW2;
                en_d[2] = 1'b1;
                ld_d[0] = 1'b1;
            end else if (state_q == SW2) begin
                state_d = SW3;
                en_d[3] = 1'b1;
                ld_d[1] = 1'b1;
                done_d  = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            bus_data_q <= 8'h00;
            en_q       <= '0;
            ld_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            bus_data_q <= bus_data_d;
            en_q       <= en_d;
            ld_q       <= ld_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.busy      = (state_q != IDLE) || !empty;
    assign bus.bus_data  = bus_data_q;
    assign bus.eni       = en_q[0];
    assign bus.ena       = en_q[1];
    assign bus.enb       = en_q[2];
    assign bus.enc       = en_q[3];
    assign bus.lda       = ld_q[0];
    assign bus.ldb       = ld_q[1];
    assign bus.ldc       = ld_q[2];
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: directed vector table, multi-cycle sequences and a random run
// checked cycle by cycle against a queue-based command/step model.
module tb_bus_xfer_ctrl;
    localparam int DEPTH = 4;
`ifdef SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_xfer_if bif();
    bus_xfer_ctrl #(.DEPTH(DEPTH), .AW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] vec(input logic [7:0] bd, input logic [3:0] en, input logic [2:0] ld,
                                        input logic done, input logic err, input logic busy, input logic rdy);
        return {bd, en, ld, done, err, busy, rdy};
    endfunction

    logic [18:0] dut_v;
    assign dut_v = vec(bif.bus_data, {bif.enc, bif.enb, bif.ena, bif.eni}, {bif.ldc, bif.ldb, bif.lda},
                       bif.done, bif.err, bif.busy, bif.cmd_ready);
    localparam logic [18:0] RST_V = {8'h00, 4'b0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Simulated bus datapath: registers A/B/C load from whichever driver is enabled.
    logic [7:0] ra, rb, rc, bus_v;
    assign bus_v = bif.eni ? bif.bus_data : bif.ena ? ra : bif.enb ? rb : rc;
    always @(posedge clk) begin
        if (bif.lda) ra <= bus_v;
        if (bif.ldb) rb <= bus_v;
        if (bif.ldc) rc <= bus_v;
    end

    int err_cnt = 0, done_cnt = 0;
    always @(negedge clk) begin
        if (bif.err)  err_cnt  <= err_cnt + 1;
        if (bif.done) done_cnt <= done_cnt + 1;
    end

    // Reference: accepted commands queue up; each expands into per-cycle bus steps.
    typedef struct {logic [3:0] en; logic [2:0] ld; logic done; logic err;} step_t;
    typedef struct {logic [1:0] op; logic [1:0] src; logic [2:0] dst; logic [7:0] data;} mcmd_t;
    mcmd_t       mq[$];
    step_t       sq[$];
    logic [7:0]  m_bus = 8'h00;
    logic [18:0] exp_v = RST_V;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete(); sq.delete(); m_bus = 8'h00;
        end else begin
            bit rdy;
            mcmd_t c;
            step_t s;
            rdy = (mq.size() < DEPTH);
            if (sq.size() > 0) void'(sq.pop_front());
            if (sq.size() == 0 && mq.size() > 0) begin
                c = mq.pop_front();
                s = '{en: 4'b0, ld: 3'b0, done: 1'b0, err: 1'b0};
                if (c.dst == 3'b0 || c.op >= 2'd2 || (c.op == 2'd1 && !SWAP)) begin
                    s.err = 1'b1; sq.push_back(s);
                end else if (c.op == 2'd0) begin
                    s.en = 4'b0001 << c.src; s.ld = c.dst; s.done = 1'b1; sq.push_back(s);
                    if (c.src == 2'd0) m_bus = c.data;
                end else begin
                    s.en = 4'b0010; s.ld = 3'b100; sq.push_back(s);
                    s.en = 4'b0100; s.ld = 3'b001; sq.push_back(s);
                    s.en = 4'b1000; s.ld = 3'b010; s.done = 1'b1; sq.push_back(s);
                end
            end
            if (bif.cmd_valid && rdy)
                mq.push_back('{op: bif.cmd_op, src: bif.cmd_src, dst: bif.cmd_dst, data: bif.cmd_data});
        end
        if (sq.size() > 0)
            exp_v = vec(m_bus, sq[0].en, sq[0].ld, sq[0].done, sq[0].err,
                        !sq[0].err || mq.size() > 0, mq.size() < DEPTH);
        else
            exp_v = vec(m_bus, 4'b0, 3'b0, 1'b0, 1'b0, mq.size() > 0, mq.size() < DEPTH);
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle", 32'(dut_v), 32'(exp_v));
            chk("onehot_en", 32'($countones({bif.eni, bif.ena, bif.enb, bif.enc}) <= 1), 32'd1);
        end
    end

    task automatic push(input logic [1:0] op, input logic [1:0] src, input logic [2:0] dst, input logic [7:0] data);
        int  n = 0;
        bit  ok = 1'b0;
        bif.cmd_valid = 1'b1; bif.cmd_op = op; bif.cmd_src = src; bif.cmd_dst = dst; bif.cmd_data = data;
        while (!ok && n < 64) begin
            ok = bif.cmd_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bif.busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("idle", 32'(bif.busy), 32'd0);
    endtask

    typedef struct {
        logic [1:0] op; logic [1:0] src; logic [2:0] dst; logic [7:0] data;
        logic [7:0] ea, eb, ec; int eerr;
    } tv_t;
    tv_t tv[10];

    initial begin
        logic [7:0] a4, b4, c4, pa, pb, pc;
        int e0, d0;
        a4 = SWAP ? 8'h22 : 8'h11;
        b4 = SWAP ? 8'h11 : 8'h22;
        c4 = SWAP ? 8'h11 : 8'h5A;
        tv[0] = '{2'd0, 2'd0, 3'b111, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 0};
        tv[1] = '{2'd0, 2'd0, 3'b001, 8'h11, 8'h11, 8'h5A, 8'h5A, 0};
        tv[2] = '{2'd0, 2'd0, 3'b010, 8'h22, 8'h11, 8'h22, 8'h5A, 0};
        tv[3] = '{2'd1, 2'd0, 3'b111, 8'h00, a4, b4, c4, SWAP ? 0 : 1};
        tv[4] = '{2'd0, 2'd0, 3'b000, 8'hEE, a4, b4, c4, 1};
        tv[5] = '{2'd3, 2'd1, 3'b100, 8'hEE, a4, b4, c4, 1};
        tv[6] = '{2'd0, 2'd1, 3'b100, 8'h00, a4, b4, a4, 0};
        tv[7] = '{2'd0, 2'd2, 3'b001, 8'h00, b4, b4, a4, 0};
        tv[8] = '{2'd0, 2'd3, 3'b011, 8'h00, a4, a4, a4, 0};
        tv[9] = '{2'd0, 2'd1, 3'b001, 8'h00, a4, a4, a4, 0};

        bif.cmd_valid = 1'b0; bif.cmd_op = '0; bif.cmd_src = '0; bif.cmd_dst = '0; bif.cmd_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(dut_v), 32'(RST_V));
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            e0 = err_cnt;
            push(tv[i].op, tv[i].src, tv[i].dst, tv[i].data);
            bif.cmd_valid = 1'b0;
            wait_idle();
            @(negedge clk);
            chk($sformatf("v%0d_A", i), 32'(ra), 32'(tv[i].ea));
            chk($sformatf("v%0d_B", i), 32'(rb), 32'(tv[i].eb));
            chk($sformatf("v%0d_C", i), 32'(rc), 32'(tv[i].ec));
            chk($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(tv[i].eerr));
        end

        // Five back-to-back MOVEs; the model flags any gap or ordering slip.
        d0 = done_cnt;
        push(2'd0, 2'd0, 3'b001, 8'h31);
        push(2'd0, 2'd0, 3'b010, 8'h32);
        push(2'd0, 2'd0, 3'b100, 8'h33);
        push(2'd0, 2'd1, 3'b010, 8'h00);
        push(2'd0, 2'd3, 3'b001, 8'h00);
        bif.cmd_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("b2b_done", 32'(done_cnt - d0), 32'd5);
        chk("b2b_A", 32'(ra), 32'h33);
        chk("b2b_B", 32'(rb), 32'h31);
        chk("b2b_C", 32'(rc), 32'h33);

        // Random traffic, mostly legal, against the model.
        for (int k = 0; k < 600; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            bif.cmd_valid = ($urandom_range(0, 9) < 7);
            bif.cmd_op    = (r < 7) ? 2'd0 : (r < 9) ? 2'd1 : 2'(2 + $urandom_range(0, 1));
            bif.cmd_src   = 2'($urandom_range(0, 3));
            bif.cmd_dst   = 3'($urandom_range(0, 7));
            bif.cmd_data  = 8'($urandom);
            @(negedge clk);
        end
        bif.cmd_valid = 1'b0;
        wait_idle();
        @(negedge clk);

        // Reset mid-command with two more queued behind it.
        pa = ra; pb = rb; pc = rc;
        if (SWAP) push(2'd1, 2'd0, 3'b111, 8'h00);
        else      push(2'd0, 2'd0, 3'b001, 8'h77);
        push(2'd0, 2'd0, 3'b010, 8'h88);
        push(2'd0, 2'd0, 3'b100, 8'h99);
        bif.cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'(dut_v), 32'(RST_V));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 32'(bif.busy), 32'd0);
        chk("post_rst_A", 32'(ra), SWAP ? 32'(pa) : 32'h77);
        chk("post_rst_B", 32'(rb), 32'(pb));
        chk("post_rst_C", 32'(rc), SWAP ? 32'(pa) : 32'(pc));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
